// File: rtl/audio_pkg.sv
// Shared widths for the I2S audio transmit path.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned TONE_W     = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned HALF_BITS  = 32;

  localparam int unsigned SHIFT_W    = 4;
  localparam int unsigned DIV_W      = 8;
  localparam int unsigned UNDERRUN_W = 8;

  localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);
  localparam int unsigned POS_W      = $clog2(HALF_BITS);
  localparam int unsigned IDX_W      = $clog2(SAMPLE_W);

endpackage

// File: rtl/tone_sat16.sv
// Arithmetic right shift of the mixed tone word, saturated to a signed 16-bit sample.
module tone_sat16
  import audio_pkg::*;
(
  input  logic [TONE_W-1:0]   value_i,
  input  logic [SHIFT_W-1:0]  shift_i,
  output logic [SAMPLE_W-1:0] sample_c_o
);

  localparam logic signed [TONE_W-1:0] SAT_MAX = TONE_W'(32'sh0000_7FFF);
  localparam logic signed [TONE_W-1:0] SAT_MIN = TONE_W'(-32'sh0000_8000);

  logic signed [TONE_W-1:0] shifted;

  always_comb begin
    shifted = $signed(value_i) >>> shift_i;
    if (shifted > SAT_MAX) begin
      sample_c_o = SAMPLE_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      sample_c_o = SAMPLE_W'(SAT_MIN);
    end else begin
      sample_c_o = shifted[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: BCLK/LRCK generation, per-frame sample hand-off and underrun counting.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [TONE_W-1:0]     TONE,
  input  logic                  TONE_VALID,
  input  logic [SHIFT_W-1:0]    GAIN_SHIFT,
  output logic                  SAMPLE_REQ,
  output logic                  AUD_BCLK,
  output logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic [UNDERRUN_W-1:0] UNDERRUN_CNT
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [BITCNT_W-1:0]   bit_q, bit_d;
  logic                  lrck_q, lrck_d;
  logic                  dat_q, dat_d;
  logic                  req_q, req_d;
  logic [UNDERRUN_W-1:0] urun_q, urun_d;
  logic [SAMPLE_W-1:0]   hold_q, hold_d;
  logic [SAMPLE_W-1:0]   frame_q, frame_d;
  logic                  fresh_q, fresh_d;

  logic [SAMPLE_W-1:0]   sat_sample;
  logic                  div_wrap;
  logic                  fall_tog;
  logic                  frame_start;
  logic                  slot_active;
  logic [BITCNT_W-1:0]   bit_next;
  logic [POS_W-1:0]      pos;
  logic [IDX_W-1:0]      slot_idx;

  tone_sat16 u_sat (
    .value_i    (TONE),
    .shift_i    (GAIN_SHIFT),
    .sample_c_o (sat_sample)
  );

  assign div_wrap    = (div_q == DIV_LAST);
  assign fall_tog    = div_wrap && bclk_q;
  assign bit_next    = bit_q + 1'b1;
  assign frame_start = fall_tog && (bit_next == '0);

  // One-BCLK delayed, MSB-first slot: positions 1..16 carry sample bits 15..0.
  assign pos         = bit_next[POS_W-1:0];
  assign slot_active = (pos != '0) && (pos <= POS_W'(SAMPLE_W));
  assign slot_idx    = IDX_W'(POS_W'(SAMPLE_W) - pos);

  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    bit_d   = bit_q;
    lrck_d  = lrck_q;
    dat_d   = dat_q;
    req_d   = 1'b0;
    urun_d  = urun_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    fresh_d = fresh_q;

    if (div_wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end

    if (fall_tog) begin
      bit_d  = bit_next;
      lrck_d = bit_next[BITCNT_W-1];
      dat_d  = slot_active ? frame_q[slot_idx] : 1'b0;
    end

    if (frame_start) begin
      frame_d = hold_q;
      fresh_d = 1'b0;
      req_d   = 1'b1;
      if (!fresh_q && (urun_q != '1)) begin
        urun_d = urun_q + 1'b1;
      end
    end

    // A sample arriving on the frame-start cycle belongs to the next frame.
    if (TONE_VALID) begin
      hold_d  = sat_sample;
      fresh_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= '1;
      lrck_q  <= 1'b1;
      dat_q   <= 1'b0;
      req_q   <= 1'b0;
      urun_q  <= '0;
      hold_q  <= '0;
      frame_q <= '0;
      fresh_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      bit_q   <= bit_d;
      lrck_q  <= lrck_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      urun_q  <= urun_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      fresh_q <= fresh_d;
    end
  end

  assign SAMPLE_REQ   = req_q;
  assign AUD_BCLK     = bclk_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dat_q;
  assign UNDERRUN_CNT = urun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: serial frames are captured per BCLK fall and compared with a frame-level model.
module tb_audio_i2s_tx;

  localparam int unsigned DIV       = 4;
  localparam int unsigned FRAME_CLK = 2 * DIV * 64;
  localparam logic [63:0] LR_WORD   = {32'h0000_0000, 32'hFFFF_FFFF};

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] TONE = '0;
  logic        TONE_VALID = 1'b0;
  logic [3:0]  GAIN_SHIFT = '0;
  logic        SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
  logic [7:0]  UNDERRUN_CNT;

  logic        RESET2 = 1'b1;
  logic [31:0] TONE2 = '0;
  logic        VALID2 = 1'b0;
  logic [3:0]  SHIFT2 = '0;
  logic        REQ2, BCLK2, LR2, DAT2;
  logic [7:0]  UR2;

  int tests = 0;
  int fails = 0;

  logic [63:0] cap_dat, cap_lr;
  int          cap_n = 0;
  logic        prev_bclk = 1'b0;
  logic [63:0] frm_dat[$];
  logic [63:0] frm_lr[$];

  logic [15:0] m_hold;
  logic        m_fresh;
  int          m_ur;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  audio_i2s_tx #(.BCLK_DIV(DIV)) u_dut (
    .CLK(CLK), .RESET(RESET), .TONE(TONE), .TONE_VALID(TONE_VALID), .GAIN_SHIFT(GAIN_SHIFT),
    .SAMPLE_REQ(SAMPLE_REQ), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT), .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  audio_i2s_tx #(.BCLK_DIV(2)) u_dut_fast (
    .CLK(CLK), .RESET(RESET2), .TONE(TONE2), .TONE_VALID(VALID2), .GAIN_SHIFT(SHIFT2),
    .SAMPLE_REQ(REQ2), .AUD_BCLK(BCLK2), .AUD_DACLRCK(LR2),
    .AUD_DACDAT(DAT2), .UNDERRUN_CNT(UR2)
  );

  // Deserialise one 64-bit frame per SAMPLE_REQ, position 0 ending up in the MSB.
  always @(negedge CLK) begin
    if (RESET) begin
      cap_n     = 0;
      prev_bclk = 1'b0;
    end else begin
      if (prev_bclk && !AUD_BCLK) begin
        if (SAMPLE_REQ) begin
          if (cap_n == 64) begin
            frm_dat.push_back(cap_dat);
            frm_lr.push_back(cap_lr);
          end
          cap_dat = 64'(AUD_DACDAT);
          cap_lr  = 64'(AUD_DACLRCK);
          cap_n   = 1;
        end else if (cap_n > 0) begin
          cap_dat = {cap_dat[62:0], AUD_DACDAT};
          cap_lr  = {cap_lr[62:0], AUD_DACLRCK};
          cap_n++;
        end
      end
      prev_bclk = AUD_BCLK;
    end
  end

  function automatic logic [63:0] frame_word(input logic [15:0] s);
    return {1'b0, s, 15'h0000, 1'b0, s, 15'h0000};
  endfunction

  // Floor division by 2**s, then clamp to the signed 16-bit range.
  function automatic logic [15:0] ref_sat(input logic [31:0] t, input logic [3:0] s);
    longint v, d;
    v = longint'($signed(t));
    d = longint'(1) << s;
    if (v >= 0) v = v / d;
    else        v = -((-v + d - 1) / d);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic model_frame_start();
    exp_q.push_back(m_hold);
    if (!m_fresh && m_ur < 255) m_ur++;
    m_fresh = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] t, input logic [3:0] s);
    m_hold  = ref_sat(t, s);
    m_fresh = 1'b1;
  endtask

  task automatic drive_valid(input logic [31:0] t, input logic [3:0] s);
    TONE       = t;
    GAIN_SHIFT = s;
    TONE_VALID = 1'b1;
    @(posedge CLK);
    #1 TONE_VALID = 1'b0;
  endtask

  // Returns one cycle after the SAMPLE_REQ pulse, between clock edges.
  task automatic wait_req();
    int k;
    k = 0;
    @(negedge CLK);
    while (SAMPLE_REQ !== 1'b1 && k < 2 * FRAME_CLK) begin
      @(negedge CLK);
      k++;
    end
    tests++;
    if (SAMPLE_REQ !== 1'b1) begin
      fails++;
      $display("FAIL wait_req: SAMPLE_REQ=%b after %0d cycles, want 1", SAMPLE_REQ, k);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    TONE_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    frm_dat.delete();
    frm_lr.delete();
    exp_q.delete();
    m_hold  = '0;
    m_fresh = 1'b1;
    m_ur    = 0;
    wait_req();
    model_frame_start();
  endtask

  task automatic test_reset();
    logic [11:0] got, want;
    int bitc;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN_CNT} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_values got=%b%b%b%b/%0d want=0100/0",
               AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN_CNT);
    end
    @(posedge CLK);
    #1 RESET = 1'b0;
    frm_dat.delete();
    frm_lr.delete();
    for (int n = 1; n <= 600; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      bitc = (n < 2 * DIV) ? 63 : ((n - 2 * DIV) / (2 * DIV)) % 64;
      want = {1'((n / DIV) % 2), 1'(n % FRAME_CLK == 2 * DIV), 1'(bitc >= 32), 1'b0,
              (n >= FRAME_CLK + 2 * DIV) ? 8'd1 : 8'd0};
      got  = {AUD_BCLK, SAMPLE_REQ, AUD_DACLRCK, AUD_DACDAT, UNDERRUN_CNT};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL timing cycle=%0d got=%h want=%h", n, got, want);
      end
    end
    tests++;
    if (frm_dat.size() != 1 || frm_dat[0] !== 64'h0 || frm_lr[0] !== LR_WORD) begin
      fails++;
      $display("FAIL first_frame count=%0d want 1 zero frame", frm_dat.size());
    end
  endtask

  task automatic test_tone_basic();
    do_reset();
    drive_valid(32'h0000_1234, 4'd0);
    wait_req();
    tests++;
    if (UNDERRUN_CNT !== 8'd0) begin
      fails++;
      $display("FAIL basic_underrun got=%0d want=0", UNDERRUN_CNT);
    end
    wait_req();
    tests++;
    if (frm_dat.size() != 2) begin
      fails++;
      $display("FAIL basic_count got=%0d want=2", frm_dat.size());
    end else if (frm_dat[0] !== 64'h0 || frm_dat[1] !== frame_word(16'h1234) || frm_lr[1] !== LR_WORD) begin
      fails++;
      $display("FAIL basic_frame got=%h want=%h", frm_dat[1], frame_word(16'h1234));
    end
  endtask

  task automatic test_clamp();
    logic [31:0] tv[3];
    logic [3:0]  sv[3];
    logic [15:0] wv[3];
    tv = '{32'h0010_0000, 32'hFFF0_0000, 32'hFFFF_FF00};
    sv = '{4'd4, 4'd0, 4'd4};
    wv = '{16'h7FFF, 16'h8000, 16'hFFF0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_valid(tv[i], sv[i]);
      wait_req();
    end
    tests++;
    if (UNDERRUN_CNT !== 8'd0) begin
      fails++;
      $display("FAIL clamp_underrun got=%0d want=0", UNDERRUN_CNT);
    end
    wait_req();
    tests++;
    if (frm_dat.size() != 4) begin
      fails++;
      $display("FAIL clamp_count got=%0d want=4", frm_dat.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (frm_dat[i+1] !== frame_word(wv[i])) begin
          fails++;
          $display("FAIL clamp_%0d got=%h want=%h", i, frm_dat[i+1], frame_word(wv[i]));
        end
      end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    drive_valid(32'h0000_5678, 4'd0);
    wait_req();
    tests++;
    if (UNDERRUN_CNT !== 8'd0) begin
      fails++;
      $display("FAIL starve_first got=%0d want=0", UNDERRUN_CNT);
    end
    repeat (3) wait_req();
    tests++;
    if (UNDERRUN_CNT !== 8'd3) begin
      fails++;
      $display("FAIL starve_count got=%0d want=3", UNDERRUN_CNT);
    end
    tests++;
    if (frm_dat.size() != 4 || frm_dat[1] !== frame_word(16'h5678) ||
        frm_dat[2] !== frame_word(16'h5678) || frm_dat[3] !== frame_word(16'h5678)) begin
      fails++;
      $display("FAIL starve_repeat count=%0d want 4 frames repeating 5678", frm_dat.size());
    end
  endtask

  task automatic test_coincident();
    do_reset();
    drive_valid(32'h0000_0AAA, 4'd0);
    repeat (FRAME_CLK - 3) @(posedge CLK);
    #1;
    drive_valid(32'h0000_0555, 4'd0);
    tests++;
    if (SAMPLE_REQ !== 1'b1) begin
      fails++;
      $display("FAIL coinc_align got=%b want=1", SAMPLE_REQ);
    end
    wait_req();
    wait_req();
    tests++;
    if (UNDERRUN_CNT !== 8'd0) begin
      fails++;
      $display("FAIL coinc_underrun got=%0d want=0", UNDERRUN_CNT);
    end
    wait_req();
    tests++;
    if (frm_dat.size() != 3 || frm_dat[1] !== frame_word(16'h0AAA) || frm_dat[2] !== frame_word(16'h0555)) begin
      fails++;
      $display("FAIL coinc_frames count=%0d want old 0AAA then new 0555", frm_dat.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] r, t;
    logic [3:0]  s;
    logic [63:0] d, l;
    logic [15:0] e;
    int nv;
    do_reset();
    for (int f = 0; f < 16; f++) begin
      nv = $urandom_range(0, 2);
      for (int v = 0; v < nv; v++) begin
        repeat ($urandom_range(1, 100)) @(posedge CLK);
        #1;
        r = $urandom;
        case ($urandom_range(0, 2))
          0:       t = r;
          1:       t = {{12{r[19]}}, r[19:0]};
          default: t = {{16{r[15]}}, r[15:0]};
        endcase
        s = 4'($urandom_range(0, 15));
        drive_valid(t, s);
        model_load(t, s);
      end
      wait_req();
      model_frame_start();
    end
    tests++;
    if (frm_dat.size() != exp_q.size() - 1) begin
      fails++;
      $display("FAIL rand_count got=%0d want=%0d", frm_dat.size(), exp_q.size() - 1);
    end
    while (frm_dat.size() > 0 && exp_q.size() > 1) begin
      d = frm_dat.pop_front();
      l = frm_lr.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (d !== frame_word(e) || l !== LR_WORD) begin
        fails++;
        $display("FAIL rand_frame got=%h/%h want=%h/%h", d, l, frame_word(e), LR_WORD);
      end
    end
    tests++;
    if (UNDERRUN_CNT !== 8'(m_ur)) begin
      fails++;
      $display("FAIL rand_underrun got=%0d want=%0d", UNDERRUN_CNT, m_ur);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got, want;
    do_reset();
    drive_valid(32'hFFFF_FFFF, 4'd0);
    wait_req();
    wait_req();
    // Stop just after bit 40 (sample bit 8 on the right channel) with BCLK high.
    repeat (40 * 2 * DIV + DIV + 1) @(posedge CLK);
    @(negedge CLK);
    tests++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, UNDERRUN_CNT} !== {1'b1, 1'b1, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL mid_before got=%b%b%b/%0d want=111/1", AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, UNDERRUN_CNT);
    end
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    tests++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN_CNT} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL mid_reset got=%b%b%b%b/%0d want=0100/0",
               AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN_CNT);
    end
    RESET = 1'b0;
    for (int n = 1; n <= 5 * DIV; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      want = {1'((n / DIV) % 2), 1'(n == 2 * DIV), 1'(n < 2 * DIV)};
      got  = {AUD_BCLK, SAMPLE_REQ, AUD_DACLRCK};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL mid_restart cycle=%0d got=%b want=%b", n, got, want);
      end
    end
  endtask

  task automatic test_underrun_saturate();
    int k_wait;
    int want;
    RESET2 = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET2 = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      k_wait = 0;
      do begin
        @(negedge CLK);
        k_wait++;
      end while (REQ2 !== 1'b1 && k_wait < 600);
      tests++;
      if (REQ2 !== 1'b1) begin
        fails++;
        $display("FAIL sat_req frame=%0d got=%b want=1", k, REQ2);
        break;
      end
      want = (k - 1 > 255) ? 255 : k - 1;
      tests++;
      if (UR2 !== 8'(want)) begin
        fails++;
        $display("FAIL sat_count frame=%0d got=%0d want=%0d", k, UR2, want);
      end
    end
  endtask

  initial begin
    fork
      test_underrun_saturate();
      begin
        test_reset();
        test_tone_basic();
        test_clamp();
        test_underrun();
        test_coincident();
        test_random();
        test_reset_mid();
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
